// File: rtl/harvard_pkg.sv
// ----------------------------------------------------------------------------
// harvard_pkg
//   Shared definitions for the Harvard accumulator machine controller:
//   field widths, opcode values, sequencer state encoding and a small
//   opcode-classification helper.
// ----------------------------------------------------------------------------
package harvard_pkg;

   localparam int HS_PC_W  = 8;   // program counter / instruction address width
   localparam int HS_DAT_W = 16;  // data, accumulator and data address width
   localparam int HS_OP_W  = 6;   // opcode field width, IR[21:16]

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_LDA = 6'h01;
   localparam logic [5:0] OP_STA = 6'h02;
   localparam logic [5:0] OP_ADD = 6'h03;
   localparam logic [5:0] OP_SUB = 6'h04;
   localparam logic [5:0] OP_LDI = 6'h05;
   localparam logic [5:0] OP_JMP = 6'h06;
   localparam logic [5:0] OP_JZ  = 6'h07;
   localparam logic [5:0] OP_JC  = 6'h08;
   localparam logic [5:0] OP_HLT = 6'h3F;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   // True for every opcode the machine implements; anything else is illegal.
   function automatic logic is_defined_op(input logic [5:0] op);
      logic known;
      case (op)
         OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB,
         OP_LDI, OP_JMP, OP_JZ, OP_JC, OP_HLT: known = 1'b1;
         default:                              known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/harvard_alu.sv
// ----------------------------------------------------------------------------
// harvard_alu
//   Combinational arithmetic unit of the sequencer.
//   a     : accumulator operand
//   b     : data operand (memory read data or immediate)
//   op    : opcode; ADD adds, SUB subtracts, anything else passes b through
//   y     : result
//   carry : ADD carry-out, SUB borrow (a < b unsigned), 0 otherwise
//   zero  : y == 0
// ----------------------------------------------------------------------------
module harvard_alu
   import harvard_pkg::*;
#(
   parameter int W = HS_DAT_W
)(
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [HS_OP_W-1:0] op,
   output logic [W-1:0]       y,
   output logic               carry,
   output logic               zero
);

   logic [W:0] wide_s;

   // One extra bit holds the carry of ADD and the borrow of SUB.
   always_comb begin
      wide_s = {1'b0, b};
      case (op)
         OP_ADD:  wide_s = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide_s = {1'b0, a} - {1'b0, b};
         default: wide_s = {1'b0, b};
      endcase
   end

   assign y     = wide_s[W-1:0];
   assign carry = wide_s[W];
   assign zero  = (wide_s[W-1:0] == {W{1'b0}});

endmodule

// File: rtl/harvard_sequencer.sv
// ----------------------------------------------------------------------------
// harvard_sequencer
//   Fetch/decode/execute controller of the Harvard accumulator machine.
//   Holds the PC, IR, FSM and flag registers; arithmetic is done by
//   harvard_alu. Every output is registered, so write pulses and flag
//   updates become visible in the cycle after EXEC and a reset taken
//   during EXEC never produces a pulse.
//   CLK     : clock, rising edge        RST_N   : async active-low reset
//   RUN     : start level (IDLE only)   I       : instruction word at PC
//   DR      : Data_MEM read data at DW  AR      : accumulator contents
//   EFF/CFF : stored zero/carry flags   PC      : instruction address
//   DW      : data address              DATA    : data write value
//   D_WE    : data write pulse          AW      : accumulator write value
//   A_WE    : accumulator write pulse   EFW/CFW : flags to Status_MEM
//   HALTED  : in HALT state             ILLEGAL : sticky undefined-opcode
// ----------------------------------------------------------------------------
module harvard_sequencer
   import harvard_pkg::*;
#(
   parameter int PC_W  = HS_PC_W,
   parameter int DAT_W = HS_DAT_W,
   parameter int OP_W  = HS_OP_W
)(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  RUN,
   input  logic [OP_W+DAT_W-1:0] I,
   input  logic [DAT_W-1:0]      DR,
   input  logic [DAT_W-1:0]      AR,
   input  logic                  EFF,
   input  logic                  CFF,
   output logic [PC_W-1:0]       PC,
   output logic [DAT_W-1:0]      DW,
   output logic [DAT_W-1:0]      DATA,
   output logic                  D_WE,
   output logic [DAT_W-1:0]      AW,
   output logic                  A_WE,
   output logic                  EFW,
   output logic                  CFW,
   output logic                  HALTED,
   output logic                  ILLEGAL
);

   localparam int IR_W = OP_W + DAT_W;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IR_W-1:0]   ir_r;
   logic [OP_W-1:0]   opcode_s;
   logic [DAT_W-1:0]  operand_s;
   logic [DAT_W-1:0]  alu_b_s;
   logic [DAT_W-1:0]  alu_y_s;
   logic              alu_carry_s;
   logic              alu_zero_s;
   logic [PC_W-1:0]   pc_inc_s;
   logic [PC_W-1:0]   pc_tgt_s;
   logic [PC_W-1:0]   pc_nxt_s;
   logic [DAT_W-1:0]  aw_nxt_s;
   logic [DAT_W-1:0]  data_nxt_s;
   logic              a_we_nxt_s;
   logic              d_we_nxt_s;
   logic              efw_nxt_s;
   logic              cfw_nxt_s;
   logic              ill_nxt_s;

   assign opcode_s  = ir_r[IR_W-1:DAT_W];
   assign operand_s = ir_r[DAT_W-1:0];
   assign pc_inc_s  = PC + {{(PC_W-1){1'b0}}, 1'b1};   // wraps at 2^PC_W
   assign pc_tgt_s  = ir_r[PC_W-1:0];

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; RUN matters only in IDLE, HALT is left only by reset.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (RUN) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH:  state_nxt_s = ST_DECODE;
         ST_DECODE: state_nxt_s = ST_EXEC;
         ST_EXEC: begin
            if (opcode_s == OP_HLT) begin
               state_nxt_s = ST_HALT;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_HALT:   state_nxt_s = ST_HALT;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // ALU second operand: the immediate for LDI, memory data otherwise.
   always_comb begin
      alu_b_s = DR;
      if (opcode_s == OP_LDI) begin
         alu_b_s = operand_s;
      end else begin
         alu_b_s = DR;
      end
   end

   harvard_alu #(
      .W     (DAT_W)
   ) u_alu (
      .a     (AR),
      .b     (alu_b_s),
      .op    (opcode_s),
      .y     (alu_y_s),
      .carry (alu_carry_s),
      .zero  (alu_zero_s)
   );

   // Effects of the instruction in IR, committed at the end of EXEC.
   always_comb begin
      pc_nxt_s   = pc_inc_s;
      aw_nxt_s   = AW;
      a_we_nxt_s = 1'b0;
      data_nxt_s = DATA;
      d_we_nxt_s = 1'b0;
      efw_nxt_s  = EFW;
      cfw_nxt_s  = CFW;
      ill_nxt_s  = ILLEGAL | ~is_defined_op(opcode_s);
      case (opcode_s)
         OP_LDA, OP_LDI: begin
            aw_nxt_s   = alu_y_s;
            a_we_nxt_s = 1'b1;
            efw_nxt_s  = alu_zero_s;
         end
         OP_ADD, OP_SUB: begin
            aw_nxt_s   = alu_y_s;
            a_we_nxt_s = 1'b1;
            efw_nxt_s  = alu_zero_s;
            cfw_nxt_s  = alu_carry_s;
         end
         OP_STA: begin
            data_nxt_s = AR;
            d_we_nxt_s = 1'b1;
         end
         OP_JMP: pc_nxt_s = pc_tgt_s;
         OP_JZ: begin
            if (EFF) begin
               pc_nxt_s = pc_tgt_s;
            end else begin
               pc_nxt_s = pc_inc_s;
            end
         end
         OP_JC: begin
            if (CFF) begin
               pc_nxt_s = pc_tgt_s;
            end else begin
               pc_nxt_s = pc_inc_s;
            end
         end
         default: pc_nxt_s = pc_inc_s;   // NOP, HLT and undefined opcodes
      endcase
   end

   // Datapath and output registers; write pulses last exactly one cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PC      <= {PC_W{1'b0}};
         ir_r    <= {IR_W{1'b0}};
         DW      <= {DAT_W{1'b0}};
         DATA    <= {DAT_W{1'b0}};
         D_WE    <= 1'b0;
         AW      <= {DAT_W{1'b0}};
         A_WE    <= 1'b0;
         EFW     <= 1'b0;
         CFW     <= 1'b0;
         HALTED  <= 1'b0;
         ILLEGAL <= 1'b0;
      end else begin
         A_WE   <= 1'b0;
         D_WE   <= 1'b0;
         HALTED <= (state_nxt_s == ST_HALT);
         case (state_r)
            ST_FETCH:  ir_r <= I;
            ST_DECODE: DW   <= operand_s;   // DR is valid during EXEC
            ST_EXEC: begin
               PC      <= pc_nxt_s;
               AW      <= aw_nxt_s;
               A_WE    <= a_we_nxt_s;
               DATA    <= data_nxt_s;
               D_WE    <= d_we_nxt_s;
               EFW     <= efw_nxt_s;
               CFW     <= cfw_nxt_s;
               ILLEGAL <= ill_nxt_s;
            end
            default: ir_r <= ir_r;
         endcase
      end
   end

endmodule

// File: tb/tb_harvard_sequencer.sv
// ----------------------------------------------------------------------------
// tb_harvard_sequencer
//   Bench for harvard_sequencer. The bench owns the instruction, data,
//   accumulator and status memories, and an instruction-level reference
//   model of the machine that predicts the architectural effect of every
//   instruction.
// ----------------------------------------------------------------------------
module tb_harvard_sequencer;

   logic        CLK;
   logic        RST_N;
   logic        RUN;
   logic [21:0] ins_s;
   logic [15:0] dr_s;
   logic [15:0] acc;
   logic        eff;
   logic        cff;
   logic [7:0]  PC;
   logic [15:0] DW;
   logic [15:0] DATA;
   logic        D_WE;
   logic [15:0] AW;
   logic        A_WE;
   logic        EFW;
   logic        CFW;
   logic        HALTED;
   logic        ILLEGAL;

   // Environment memories.
   logic [21:0] imem [256];
   logic [15:0] dmem [256];

   // Reference model state.
   logic [7:0]  m_pc;
   logic [15:0] m_acc;
   logic [15:0] m_dmem [256];
   logic        m_z, m_c, m_ill, m_halt, m_awe, m_dwe;
   logic [15:0] m_aw, m_data, m_dw;

   int n_checks;
   int n_errors;

   assign ins_s = imem[PC];
   assign dr_s  = dmem[DW[7:0]];

   harvard_sequencer dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .RUN     (RUN),
      .I       (ins_s),
      .DR      (dr_s),
      .AR      (acc),
      .EFF     (eff),
      .CFF     (cff),
      .PC      (PC),
      .DW      (DW),
      .DATA    (DATA),
      .D_WE    (D_WE),
      .AW      (AW),
      .A_WE    (A_WE),
      .EFW     (EFW),
      .CFW     (CFW),
      .HALTED  (HALTED),
      .ILLEGAL (ILLEGAL)
   );

   // Clock generation.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // One clock: memories capture the pulses/flags present before the edge.
   task automatic tick();
      logic        a_we_q, d_we_q, efw_q, cfw_q;
      logic [15:0] aw_q, dw_q, data_q;
      a_we_q = A_WE; aw_q = AW; d_we_q = D_WE; dw_q = DW; data_q = DATA;
      efw_q = EFW; cfw_q = CFW;
      @(posedge CLK);
      #1;
      if (a_we_q) acc = aw_q;
      if (d_we_q) dmem[dw_q[7:0]] = data_q;
      eff = efw_q;
      cff = cfw_q;
   endtask

   task automatic set_dmem(input int a, input logic [15:0] v);
      dmem[a]   = v;
      m_dmem[a] = v;
   endtask

   task automatic model_reset();
      m_pc = 8'd0; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0; m_halt = 1'b0;
      m_aw = 16'd0; m_data = 16'd0; m_dw = 16'd0;
   endtask

   // Pulse reset between clock edges and restart the model.
   task automatic do_reset();
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
      model_reset();
   endtask

   // Execute one instruction from FETCH and compare its architectural effect.
   task automatic run_instr(input bit rand_run);
      logic [5:0]  op;
      logic [15:0] opd;
      logic [7:0]  a;
      int          s;
      chk("fetch_pc", PC, m_pc);
      op = imem[m_pc][21:16];
      opd = imem[m_pc][15:0];
      a = opd[7:0];
      m_awe = 1'b0;
      m_dwe = 1'b0;
      m_dw = opd;
      case (op)
         6'h00: m_pc = m_pc + 8'd1;
         6'h01: begin m_acc = m_dmem[a]; m_aw = m_acc; m_awe = 1'b1; m_z = (m_acc == 0); m_pc = m_pc + 8'd1; end
         6'h02: begin m_dmem[a] = m_acc; m_data = m_acc; m_dwe = 1'b1; m_pc = m_pc + 8'd1; end
         6'h03: begin
            s = int'(m_acc) + int'(m_dmem[a]);
            m_c = (s > 65535); m_acc = 16'(s % 65536);
            m_aw = m_acc; m_awe = 1'b1; m_z = (m_acc == 0); m_pc = m_pc + 8'd1;
         end
         6'h04: begin
            m_c = (m_acc < m_dmem[a]); m_acc = m_acc - m_dmem[a];
            m_aw = m_acc; m_awe = 1'b1; m_z = (m_acc == 0); m_pc = m_pc + 8'd1;
         end
         6'h05: begin m_acc = opd; m_aw = m_acc; m_awe = 1'b1; m_z = (m_acc == 0); m_pc = m_pc + 8'd1; end
         6'h06: m_pc = a;
         6'h07: m_pc = m_z ? a : m_pc + 8'd1;
         6'h08: m_pc = m_c ? a : m_pc + 8'd1;
         6'h3F: begin m_halt = 1'b1; m_pc = m_pc + 8'd1; end
         default: begin m_ill = 1'b1; m_pc = m_pc + 8'd1; end
      endcase
      if (rand_run) RUN = 1'($urandom_range(0, 1));
      tick();
      chk("decode_no_pulse", {A_WE, D_WE}, 2'b00);
      if (rand_run) RUN = 1'($urandom_range(0, 1));
      tick();
      if (rand_run) RUN = 1'($urandom_range(0, 1));
      tick();
      chk("pc", PC, m_pc);
      chk("aw", AW, m_aw);
      chk("a_we", A_WE, m_awe);
      chk("dw", DW, m_dw);
      chk("data", DATA, m_data);
      chk("d_we", D_WE, m_dwe);
      chk("efw", EFW, m_z);
      chk("cfw", CFW, m_c);
      chk("illegal", ILLEGAL, m_ill);
      chk("halted", HALTED, m_halt);
   endtask

   initial begin
      logic [5:0] rop;
      int         r;
      n_checks = 0;
      n_errors = 0;
      RST_N = 1'b0;
      RUN   = 1'b0;
      acc   = 16'd0;
      m_acc = 16'd0;
      eff   = 1'b0;
      cff   = 1'b0;
      for (int i = 0; i < 256; i++) begin
         imem[i] = 22'd0;
         set_dmem(i, 16'($urandom));
      end
      model_reset();
      #12;
      chk("reset_outputs", {PC, DW, DATA, AW, D_WE, A_WE, EFW, CFW, HALTED, ILLEGAL}, 64'd0);

      // Reset in the middle of EXEC of STA aborts the write.
      imem[0] = {6'h02, 16'h0010};
      set_dmem(16'h10, 16'hBEEF);
      acc = 16'h1234;
      m_acc = 16'h1234;
      RST_N = 1'b1;
      RUN = 1'b1;
      tick(); tick(); tick();
      chk("sta_exec_dw", DW, 16'h0010);
      #3;
      RST_N = 1'b0;
      #1;
      chk("abort_outputs", {PC, DW, DATA, AW, D_WE, A_WE, EFW, CFW, HALTED, ILLEGAL}, 64'd0);
      tick(); tick();
      chk("abort_no_dwe", D_WE, 1'b0);
      chk("abort_mem", dmem[16'h10], 16'hBEEF);
      RST_N = 1'b1;
      RUN = 1'b0;
      tick(); tick(); tick();
      chk("idle_pc", PC, 8'd0);
      chk("idle_no_pulse", {A_WE, D_WE}, 2'b00);

      // Directed program.
      model_reset();
      set_dmem(16'h11, 16'h0001);
      set_dmem(16'h12, 16'h0005);
      imem[8'h00] = {6'h05, 16'h0005};   // LDI 5
      imem[8'h01] = {6'h02, 16'h0010};   // STA 0x10
      imem[8'h02] = {6'h05, 16'hFFFF};   // LDI 0xFFFF
      imem[8'h03] = {6'h03, 16'h0011};   // ADD [0x11]=1
      imem[8'h04] = {6'h07, 16'h0020};   // JZ 0x20
      imem[8'h20] = {6'h05, 16'h0003};   // LDI 3
      imem[8'h21] = {6'h04, 16'h0012};   // SUB [0x12]=5
      imem[8'h22] = {6'h08, 16'h0040};   // JC 0x40
      imem[8'h40] = {6'h07, 16'h0000};   // JZ 0 (not taken)
      imem[8'h41] = {6'h06, 16'h00FE};   // JMP 0xFE
      imem[8'hFE] = {6'h2A, 16'h0010};   // undefined opcode
      imem[8'hFF] = {6'h00, 16'h0000};   // NOP, PC wraps
      RUN = 1'b1;
      tick();
      run_instr(1'b0);
      chk("ldi_aw", {A_WE, AW}, {1'b1, 16'h0005});
      run_instr(1'b0);
      chk("sta_write", {D_WE, DW, DATA}, {1'b1, 16'h0010, 16'h0005});
      chk("sta_pc", PC, 8'd2);
      run_instr(1'b0);
      chk("sta_mem", dmem[16'h10], 16'h0005);
      run_instr(1'b0);
      chk("add_result", {AW, EFW, CFW}, {16'h0000, 1'b1, 1'b1});
      run_instr(1'b0);
      chk("jz_taken", PC, 8'h20);
      run_instr(1'b0);
      run_instr(1'b0);
      chk("sub_result", {AW, CFW, EFW}, {16'hFFFE, 1'b1, 1'b0});
      run_instr(1'b0);
      chk("jc_taken", PC, 8'h40);
      run_instr(1'b0);
      chk("jz_not_taken", PC, 8'h41);
      run_instr(1'b0);
      run_instr(1'b0);
      chk("illegal_op", {ILLEGAL, A_WE, D_WE, PC}, {1'b1, 1'b0, 1'b0, 8'hFF});
      run_instr(1'b0);
      chk("pc_wrap", PC, 8'h00);

      // Randomized program against the reference model.
      for (int i = 0; i < 256; i++) begin
         r = $urandom_range(0, 39);
         if (r < 3)       rop = 6'h00;
         else if (r < 9)  rop = 6'h01;
         else if (r < 14) rop = 6'h02;
         else if (r < 20) rop = 6'h03;
         else if (r < 25) rop = 6'h04;
         else if (r < 31) rop = 6'h05;
         else if (r < 33) rop = 6'h06;
         else if (r < 36) rop = 6'h07;
         else if (r < 39) rop = 6'h08;
         else             rop = 6'($urandom_range(9, 62));
         if (rop == 6'h05)
            imem[i] = {rop, ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom)};
         else
            imem[i] = {rop, 8'h00, 8'($urandom_range(0, 255))};
      end
      do_reset();
      RUN = 1'b1;
      tick();
      for (int k = 0; k < 300; k++) run_instr(1'b1);
      tick();
      for (int i = 0; i < 256; i += 17) chk("dmem_final", dmem[i], m_dmem[i]);

      // HALT: PC frozen, RUN ignored, only reset leaves it.
      do_reset();
      imem[0] = {6'h3F, 16'h0000};
      RUN = 1'b1;
      tick();
      run_instr(1'b0);
      for (int k = 0; k < 8; k++) begin
         RUN = 1'($urandom_range(0, 1));
         tick();
      end
      chk("halt_frozen", {HALTED, PC, A_WE, D_WE}, {1'b1, 8'd1, 1'b0, 1'b0});
      RST_N = 1'b0;
      #1;
      chk("halt_reset", {HALTED, PC}, {1'b0, 8'd0});
      RST_N = 1'b1;
      RUN = 1'b0;
      model_reset();
      tick(); tick(); tick();
      chk("halt_to_idle", {HALTED, PC}, {1'b0, 8'd0});
      RUN = 1'b1;
      tick();
      run_instr(1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
